// File: rtl/oh_sleepctrl.sv
// oh_sleepctrl: sleep-entry / sleep-exit sequencer for a gated core clock.
// Halts the core, waits for it to drain, drops clk_en, then wakes on an
// event edge or a timeout and holds the core halted for PD settle cycles.
//
// Ports:
//   clkin       free-running clock
//   nreset      asynchronous active-low reset
//   sleep_req   level request to enter sleep
//   wakeup      wakeup event levels (synchronous to clkin)
//   wake_mask   1 = event bit enabled as wakeup source
//   timer_en    enable timeout wakeup
//   timer_val   timeout value, sampled on SLEEP entry
//   core_idle   core has no outstanding work
//   core_halt   core must not issue new work
//   clk_en      clock-gate enable for the core clock
//   sleep_ack   high while in SLEEP
//   wake_cause  [N] = timer, [N-1:0] = event edges that ended sleep/drain
//   state       0 = ACTIVE, 1 = DRAIN, 2 = SLEEP, 3 = WAKE

module oh_sleepctrl #(
   parameter int N  = 5,
   parameter int CW = 16,
   parameter int PD = 4
) (
   input  logic          clkin,
   input  logic          nreset,
   input  logic          sleep_req,
   input  logic [N-1:0]  wakeup,
   input  logic [N-1:0]  wake_mask,
   input  logic          timer_en,
   input  logic [CW-1:0] timer_val,
   input  logic          core_idle,
   output logic          core_halt,
   output logic          clk_en,
   output logic          sleep_ack,
   output logic [N:0]    wake_cause,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SLEEP  = 2'd2,
      ST_WAKE   = 2'd3
   } state_t;

   // Settle counter runs 0..PD-1 while in WAKE.
   localparam int SW = (PD > 1) ? $clog2(PD) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(PD - 1);

   state_t        state_q, state_d;
   logic [N-1:0]  wake_prev_q, wake_prev_d;
   logic          armed_q, armed_d;
   logic [1:0]    idle_q, idle_d;
   logic [CW-1:0] timer_q, timer_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [N:0]    cause_q, cause_d;
   logic          clk_en_q;
   logic          halt_q;
   logic          ack_q;

   logic [N-1:0]  evt_edge;
   logic          any_edge;
   logic          timeout;

   // Rising edges of enabled event inputs. History resets to 0, so a
   // level already high out of reset is seen as an edge.
   assign evt_edge = wakeup & ~wake_prev_q & wake_mask;
   assign any_edge = |evt_edge;
   assign timeout  = timer_en && (timer_q == '0);

   always_comb begin
      state_d     = state_q;
      wake_prev_d = wakeup;
      armed_d     = armed_q;
      idle_d      = idle_q;
      timer_d     = timer_q;
      settle_d    = settle_q;
      cause_d     = cause_q;

      // A low request re-arms; leaving DRAIN/SLEEP with the request
      // still high disarms, so a held request cannot loop into sleep.
      if (!sleep_req) begin
         armed_d = 1'b1;
      end

      unique case (state_q)
         ST_ACTIVE: begin
            if (sleep_req && armed_q) begin
               state_d = ST_DRAIN;
               cause_d = '0;
               idle_d  = '0;
            end
         end

         ST_DRAIN: begin
            if (any_edge) begin
               // Abort takes priority over idle completion.
               state_d = ST_ACTIVE;
               cause_d = {1'b0, evt_edge};
               armed_d = !sleep_req;
            end else if (!sleep_req) begin
               state_d = ST_ACTIVE;
            end else if (core_idle && (idle_q == 2'd1)) begin
               state_d = ST_SLEEP;
               timer_d = timer_val;
               idle_d  = 2'd2;
               armed_d = 1'b0;
            end else if (core_idle) begin
               idle_d = idle_q + 2'd1;
            end else begin
               idle_d = '0;
            end
         end

         ST_SLEEP: begin
            // Timer stops at 0; timeout fires there so it never wraps.
            if (timer_en && (timer_q != '0)) begin
               timer_d = timer_q - CW'(1);
            end
            if (any_edge || timeout) begin
               state_d  = ST_WAKE;
               cause_d  = {timeout, evt_edge};
               settle_d = '0;
               armed_d  = !sleep_req;
            end
         end

         ST_WAKE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = ST_ACTIVE;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end

         default: begin
            state_d = ST_ACTIVE;
         end
      endcase
   end

   // Outputs are registered from the next state so they switch together
   // with the state register and drive the clock gate from a flop.
   always_ff @(posedge clkin or negedge nreset) begin
      if (!nreset) begin
         state_q     <= ST_ACTIVE;
         wake_prev_q <= '0;
         armed_q     <= 1'b1;
         idle_q      <= '0;
         timer_q     <= '0;
         settle_q    <= '0;
         cause_q     <= '0;
         clk_en_q    <= 1'b1;
         halt_q      <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wake_prev_q <= wake_prev_d;
         armed_q     <= armed_d;
         idle_q      <= idle_d;
         timer_q     <= timer_d;
         settle_q    <= settle_d;
         cause_q     <= cause_d;
         clk_en_q    <= (state_d != ST_SLEEP);
         halt_q      <= (state_d != ST_ACTIVE);
         ack_q       <= (state_d == ST_SLEEP);
      end
   end

   assign clk_en     = clk_en_q;
   assign core_halt  = halt_q;
   assign sleep_ack  = ack_q;
   assign wake_cause = cause_q;
   assign state      = state_q;

endmodule

// File: tb/tb_oh_sleepctrl.sv
// tb_oh_sleepctrl: directed scoreboard bench for oh_sleepctrl.
// Expected state transitions are queued; a monitor checks each one.

module tb_oh_sleepctrl;

   localparam int N  = 5;
   localparam int CW = 16;
   localparam int PD = 4;

   logic          clkin = 1'b0;
   logic          nreset;
   logic          sleep_req;
   logic [N-1:0]  wakeup;
   logic [N-1:0]  wake_mask;
   logic          timer_en;
   logic [CW-1:0] timer_val;
   logic          core_idle;
   logic          core_halt;
   logic          clk_en;
   logic          sleep_ack;
   logic [N:0]    wake_cause;
   logic [1:0]    state;

   oh_sleepctrl #(.N(N), .CW(CW), .PD(PD)) dut (
      .clkin      (clkin),
      .nreset     (nreset),
      .sleep_req  (sleep_req),
      .wakeup     (wakeup),
      .wake_mask  (wake_mask),
      .timer_en   (timer_en),
      .timer_val  (timer_val),
      .core_idle  (core_idle),
      .core_halt  (core_halt),
      .clk_en     (clk_en),
      .sleep_ack  (sleep_ack),
      .wake_cause (wake_cause),
      .state      (state)
   );

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic       ce;
      logic       ht;
      logic       ak;
      logic [N:0] cause;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   prev_st = -1;
   int   b;

   always #5 clkin = ~clkin;

   always @(posedge clkin) cyc <= cyc + 1;

   // Output table per state: ACTIVE/DRAIN/SLEEP/WAKE.
   function automatic void push(int c, logic [1:0] st, logic [N:0] cause);
      exp_t e;
      e.cyc   = c;
      e.st    = st;
      e.ce    = (st != 2'd2);
      e.ht    = (st != 2'd0);
      e.ak    = (st == 2'd2);
      e.cause = cause;
      exp_q.push_back(e);
   endfunction

   task automatic check(string name, int act, int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clkin);
      #1;
   endtask

   task automatic at(int t);
      while (cyc < t) begin
         @(posedge clkin);
         #1;
      end
   endtask

   // Monitor: every change of state is one DUT output event.
   initial begin
      exp_t e;
      forever begin
         @(negedge clkin);
         if (int'(state) != prev_st) begin
            prev_st = int'(state);
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_transition: cyc=%0d st=%0d cause=%b",
                        cyc, state, wake_cause);
            end else begin
               e = exp_q.pop_front();
               if ((e.cyc >= 0 && e.cyc != cyc) || state != e.st ||
                   clk_en != e.ce || core_halt != e.ht ||
                   sleep_ack != e.ak || wake_cause != e.cause) begin
                  miscompares++;
                  $display({"FAIL transition: got cyc=%0d st=%0d ce=%b ht=%b",
                            " ak=%b cause=%b, want cyc=%0d st=%0d ce=%b ht=%b",
                            " ak=%b cause=%b"},
                           cyc, state, clk_en, core_halt, sleep_ack,
                           wake_cause, e.cyc, e.st, e.ce, e.ht, e.ak,
                           e.cause);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      nreset    = 1'b0;
      sleep_req = 1'b0;
      wakeup    = '0;
      wake_mask = '0;
      timer_en  = 1'b0;
      timer_val = '0;
      core_idle = 1'b0;
      push(-1, 2'd0, 6'b000000);
      step(3);
      nreset = 1'b1;
      step(2);

      // Basic entry/exit, then no re-entry while held, re-entry after pulse
      b = cyc;
      sleep_req = 1'b1;
      wake_mask = 5'b00100;
      push(b + 1,  2'd1, 6'b000000);
      push(b + 5,  2'd2, 6'b000000);
      push(b + 21, 2'd3, 6'b000100);
      push(b + 25, 2'd0, 6'b000100);
      push(b + 37, 2'd1, 6'b000000);
      push(b + 39, 2'd2, 6'b000000);
      push(b + 44, 2'd3, 6'b000100);
      push(b + 48, 2'd0, 6'b000100);
      at(b + 3);  core_idle = 1'b1;
      at(b + 20); wakeup = 5'b00100;
      at(b + 35); sleep_req = 1'b0;
      at(b + 36); sleep_req = 1'b1;
      at(b + 41); wakeup = '0;
      at(b + 43); wakeup = 5'b00100;
      at(b + 44); sleep_req = 1'b0;
      at(b + 50); wakeup = '0; core_idle = 1'b0;

      // Timeout, timer_val = 10 -> 11 SLEEP cycles
      b = cyc;
      timer_en  = 1'b1;
      timer_val = 16'd10;
      core_idle = 1'b1;
      wake_mask = '0;
      sleep_req = 1'b1;
      push(b + 1,  2'd1, 6'b000000);
      push(b + 3,  2'd2, 6'b000000);
      push(b + 14, 2'd3, 6'b100000);
      push(b + 18, 2'd0, 6'b100000);
      at(b + 3); sleep_req = 1'b0;
      at(b + 20);

      // Timeout, timer_val = 0 -> 1 SLEEP cycle
      b = cyc;
      timer_val = 16'd0;
      sleep_req = 1'b1;
      push(b + 1, 2'd1, 6'b000000);
      push(b + 3, 2'd2, 6'b000000);
      push(b + 4, 2'd3, 6'b100000);
      push(b + 8, 2'd0, 6'b100000);
      at(b + 3); sleep_req = 1'b0;
      at(b + 10);

      // Abort in DRAIN; masked-out edge first has no effect
      b = cyc;
      timer_en  = 1'b0;
      core_idle = 1'b0;
      wake_mask = 5'b00010;
      sleep_req = 1'b1;
      push(b + 1, 2'd1, 6'b000000);
      push(b + 6, 2'd0, 6'b000010);
      at(b + 3); wakeup = 5'b01000;
      at(b + 5); wakeup = 5'b01010;
      at(b + 8); sleep_req = 1'b0; wakeup = '0;
      at(b + 10);

      // Timeout and event edge in the same SLEEP cycle
      b = cyc;
      timer_en  = 1'b1;
      timer_val = 16'd3;
      core_idle = 1'b1;
      wake_mask = 5'b00001;
      sleep_req = 1'b1;
      push(b + 1,  2'd1, 6'b000000);
      push(b + 3,  2'd2, 6'b000000);
      push(b + 7,  2'd3, 6'b100001);
      push(b + 11, 2'd0, 6'b100001);
      at(b + 3); sleep_req = 1'b0;
      at(b + 6); wakeup = 5'b00001;
      at(b + 7); wakeup = '0;
      at(b + 13);

      // Edge together with the second idle cycle: abort wins
      b = cyc;
      timer_en  = 1'b0;
      core_idle = 1'b0;
      sleep_req = 1'b1;
      push(b + 1, 2'd1, 6'b000000);
      push(b + 4, 2'd0, 6'b000001);
      at(b + 2); core_idle = 1'b1;
      at(b + 3); wakeup = 5'b00001;
      at(b + 5); sleep_req = 1'b0; wakeup = '0; core_idle = 1'b0;
      at(b + 7);

      // Cancel in DRAIN clears the previous cause
      b = cyc;
      sleep_req = 1'b1;
      push(b + 1, 2'd1, 6'b000000);
      push(b + 3, 2'd0, 6'b000000);
      at(b + 2); sleep_req = 1'b0;
      at(b + 5);

      // Asynchronous reset while in SLEEP
      b = cyc;
      core_idle = 1'b1;
      sleep_req = 1'b1;
      push(b + 1, 2'd1, 6'b000000);
      push(b + 3, 2'd2, 6'b000000);
      push(b + 5, 2'd0, 6'b000000);
      at(b + 5);
      check("sleep_ack_before_reset", int'(sleep_ack), 1);
      #2;
      nreset = 1'b0;
      #1;
      check("async_clk_en", int'(clk_en), 1);
      check("async_core_halt", int'(core_halt), 0);
      check("async_state", int'(state), 0);
      sleep_req = 1'b0;
      core_idle = 1'b0;
      at(b + 7);
      nreset = 1'b1;
      at(b + 10);

      step(2);
      check("pending_transitions", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/oh_sleepctrl.md
Name: oh_sleepctrl

Overview:
Sleep-entry and sleep-exit sequencer. It decides when a core may stop its clock and when the clock comes back; the clock-gating side only consumes its result.
- Accepts a level sleep request.
- Halts the core and waits for it to drain.
- Drops the clock enable, then wakes on a masked external event edge or a programmable timeout.
- Restores the clock and holds the core halted for a settle period before release.
- Runs on the free-running clock; its clk_en output drives the clock-gate enable of the core clock domain.

Parameters:
N, 5, number of wakeup event inputs
CW, 16, width of sleep timeout counter
PD, 4, settle cycles in WAKE with clock running and core still halted (PD >= 1)

Ports:
clkin  input  1  free-running clock (one clock domain only)
nreset  input  1  asynchronous active-low reset
sleep_req  input  1  level request to enter sleep
wakeup  input  N  wakeup event levels, synchronous to clkin
wake_mask  input  N  1 = event bit enabled as wakeup source
timer_en  input  1  enable timeout wakeup
timer_val  input  CW  timeout value, sampled on SLEEP entry
core_idle  input  1  core has no outstanding work
core_halt  output  1  core must not issue new work
clk_en  output  1  clock-gate enable for core clock
sleep_ack  output  1  high while in SLEEP
wake_cause  output  N+1  [N] = timer, [N-1:0] = event edges that ended sleep/drain
state  output  2  0 = ACTIVE, 1 = DRAIN, 2 = SLEEP, 3 = WAKE

Behaviour:
- Reset (async, nreset low) forces the following immediately, including mid-operation:
  - state = ACTIVE, clk_en = 1, core_halt = 0, sleep_ack = 0.
  - wake_cause = 0, timer = 0, settle counter = 0, idle counter = 0, armed = 1, edge-detect history = 0.
- Outputs are decoded from the state register (Moore). They change in the same cycle state changes.
- Edge detect: edge[i] = wakeup[i] & ~wakeup_prev[i] & wake_mask[i]. wakeup_prev is registered every cycle.
  - A level already high out of reset counts as an edge in cycle 1.
  - Edges are ignored in ACTIVE and WAKE.
- ACTIVE: clk_en = 1, core_halt = 0.
  - armed is cleared when leaving DRAIN or SLEEP.
  - armed is set again when sleep_req is sampled low.
  - Transition to DRAIN next cycle if sleep_req = 1 and armed = 1.
  - Result: a request held high across a wake cycle does not re-enter sleep.
- DRAIN: clk_en = 1, core_halt = 1. wake_cause cleared on entry.
  - Idle counter counts consecutive core_idle = 1 cycles and resets on core_idle = 0.
  - Idle counter reaches 2 -> SLEEP next cycle. Timer is loaded with timer_val.
  - Any edge -> abort: wake_cause[N-1:0] = edge, then ACTIVE next cycle. sleep_ack never asserts.
  - sleep_req dropping to 0 -> ACTIVE (cancel), wake_cause unchanged.
  - Edge and idle completion in the same cycle: abort wins.
- SLEEP: clk_en = 0, core_halt = 1, sleep_ack = 1.
  - Each cycle, if timer_en = 1: timer == 0 -> timeout, else timer decrements.
  - timer_val = T gives T+1 SLEEP cycles. timer_en = 0 disables timeout; the timer holds.
  - Exit on any edge or timeout -> WAKE next cycle.
  - On exit, wake_cause = {timeout, edge}; both set if simultaneous.
  - sleep_req is ignored in SLEEP.
- WAKE: clk_en = 1, core_halt = 1, sleep_ack = 0.
  - Stays exactly PD cycles, then ACTIVE.
- wake_cause is held until the next DRAIN entry.
- Timer width is CW bits; the timer never wraps. It stops at 0 because timeout fires there.

Test Plan:
- Reset with sleep_req = 0 -> state = 0, clk_en = 1, core_halt = 0, wake_cause = 0. Assert nreset low while in SLEEP -> clk_en = 1 asynchronously.
- Basic entry/exit (N=5, PD=4): sleep_req = 1 at cycle 0, core_idle = 1 from cycle 3, wake_mask = 5'b00100, wakeup[2] rises at cycle 20. Required:
  - DRAIN at cycle 1, SLEEP at cycle 5 (core_idle counted at cycles 3 and 4), sleep_ack = 1.
  - WAKE at cycle 21, ACTIVE at cycle 25, wake_cause = 6'b000100.
  - No re-entry while sleep_req stays high; re-entry after a low pulse.
- Timeout: timer_en = 1, timer_val = 10, no events -> exactly 11 SLEEP cycles, wake_cause = 6'b100000. Also timer_val = 0 -> 1 SLEEP cycle.
- Abort: event edge on a masked-in bit while in DRAIN with core_idle = 0 -> ACTIVE next cycle, sleep_ack never 1, clk_en never 0. A masked-out bit edge -> no effect.
- Simultaneous: timer reaches 0 in the same cycle as wakeup[0] edge -> wake_cause = 6'b100001. Edge in the same cycle as the second core_idle cycle in DRAIN -> abort.
- Cancel: sleep_req drops during DRAIN -> ACTIVE next cycle, core_halt = 0, wake_cause = 0 (cleared on DRAIN entry).
